huffman_canon_decoder: RTL and testbench

//  Parametrised, table-driven canonical-Huffman bit-serial decoder; successor to the fixed 7-symbol receiver FSM.

---
 rtl/huffman_canon_decoder_pkg.sv | 26 ++
 rtl/huffman_canon_decoder_if.sv | 29 ++
 rtl/huffman_canon_decoder_code_table.sv | 51 +++++
 rtl/huffman_canon_decoder.sv | 125 ++++++++++++
 tb/tb_huffman_canon_decoder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/huffman_canon_decoder_pkg.sv
// Shared constants for the canonical-Huffman decoder: default build sizes, cfg_sel encodings,
// decode-state type and the reset-time code table (7 symbols, lengths 2/2/3/3/3/4/4).
package huffman_pkg;

  localparam int DEF_SYM_W   = 3;
  localparam int DEF_MAX_LEN = 4;

  localparam logic CFG_SEL_COUNT = 1'b0;
  localparam logic CFG_SEL_SYM   = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_ACC
  } dec_state_t;

  // Number of codes of length len_idx+1 in the power-up table; sym[i]=i.
  function automatic int def_count(input int len_idx);
    case (len_idx)
      1:       return 2;
      2:       return 3;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/huffman_canon_decoder_if.sv
// Decoder bus: table config port, serial code-bit input (valid/ready), symbol output (valid/ready)
// and status. master drives bits/config/out_ready, slave is the decoder.
interface huffman_canon_decoder_if #(
  parameter int SYM_W = 3,
  parameter int CNT_W = SYM_W + 1
);
  logic             cfg_we;
  logic             cfg_sel;
  logic [SYM_W-1:0] cfg_addr;
  logic [CNT_W-1:0] cfg_data;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic [SYM_W-1:0] out_sym;
  logic             out_ready;
  logic             err_invalid;
  logic             busy;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_data, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_sym, err_invalid, busy
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_data, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_sym, err_invalid, busy
  );
endinterface

// File: rtl/huffman_canon_decoder_code_table.sv
// Per-length code counts and symbol table: single write port, combinational read, defaults at reset.
// Writes land on the clock edge; reads reflect the new contents from the following cycle.
module huffman_code_table
  import huffman_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = SYM_W + 1,
  parameter int LEN_W   = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_we,
  input  logic             i_sel,
  input  logic [SYM_W-1:0] i_addr,
  input  logic [CNT_W-1:0] i_data,
  input  logic [LEN_W-1:0] i_len,
  input  logic [SYM_W-1:0] i_sym_addr,
  output logic [CNT_W-1:0] o_count,
  output logic [SYM_W-1:0] o_sym
);
  localparam int NUM_SYM = 2 ** SYM_W;
  localparam int NUM_LEN = 2 ** LEN_W;

  logic [CNT_W-1:0] r_count [NUM_LEN];
  logic [SYM_W-1:0] r_sym   [NUM_SYM];
  logic             w_len_ok;

  assign w_len_ok = (int'(i_addr) < MAX_LEN);

  // Count slots past MAX_LEN exist only to make the length index full-range; they stay zero.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_LEN; i++)
        r_count[i] <= (i < MAX_LEN) ? CNT_W'(def_count(i)) : '0;
      for (int i = 0; i < NUM_SYM; i++)
        r_sym[i] <= SYM_W'(i);
    end else if (i_we) begin
      if (i_sel == CFG_SEL_COUNT) begin
        if (w_len_ok)
          r_count[LEN_W'(i_addr)] <= i_data;
      end else begin
        r_sym[i_addr] <= i_data[SYM_W-1:0];
      end
    end
  end

  assign o_count = r_count[i_len];
  assign o_sym   = r_sym[i_sym_addr];

endmodule

// File: rtl/huffman_canon_decoder.sv
// Bit-serial canonical-Huffman decoder: one code bit per cycle, symbol/error registered 1 cycle after
// the last bit. in_ready drops while an undelivered symbol is stalled or a table write is in progress.
module huffman_canon_decoder
  import huffman_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = SYM_W + 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  huffman_canon_decoder_if.slave if_dec
);
  localparam int NUM_SYM = 2 ** SYM_W;
  localparam int LEN_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW      = MAX_LEN + 1;
  localparam int IW      = SYM_W + 1;
  localparam int WW      = CW + CNT_W + IW;

  dec_state_t         r_state, w_state_nxt;
  logic [MAX_LEN-1:0] r_code, w_code_nxt;
  logic [CW-1:0]      r_first, w_first_nxt;
  logic [IW-1:0]      r_index, w_index_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic               r_out_vld, w_out_vld_nxt;
  logic [SYM_W-1:0]   r_out_sym, w_out_sym_nxt;
  logic               r_err, w_err_nxt;

  logic               w_in_ready, w_accept, w_hit, w_ovf, w_last;
  logic [CNT_W-1:0]   w_count;
  logic [SYM_W-1:0]   w_sym;
  logic [CW-1:0]      w_c;
  logic [WW-1:0]      w_c_ext, w_first_ext, w_diff, w_sidx;

  huffman_code_table #(
    .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)
  ) u_table (
    .Clock      (Clock),
    .Reset      (Reset),
    .i_we       (if_dec.cfg_we),
    .i_sel      (if_dec.cfg_sel),
    .i_addr     (if_dec.cfg_addr),
    .i_data     (if_dec.cfg_data),
    .i_len      (r_len),
    .i_sym_addr (w_sidx[SYM_W-1:0]),
    .o_count    (w_count),
    .o_sym      (w_sym)
  );

  assign w_in_ready = !(r_out_vld && !if_dec.out_ready) && !if_dec.cfg_we;
  assign w_accept   = if_dec.in_valid && w_in_ready;

  // Compare in a wide domain so c < first and oversize counts cannot wrap into a false match.
  assign w_c         = {r_code, if_dec.in_bit};
  assign w_c_ext     = WW'(w_c);
  assign w_first_ext = WW'(r_first);
  assign w_diff      = w_c_ext - w_first_ext;
  assign w_hit       = (w_c_ext >= w_first_ext) && (w_diff < WW'(w_count));
  assign w_sidx      = WW'(r_index) + w_diff;
  assign w_ovf       = (w_sidx >= WW'(NUM_SYM));
  assign w_last      = (r_len == LEN_W'(MAX_LEN - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_first_nxt   = r_first;
    w_index_nxt   = r_index;
    w_len_nxt     = r_len;
    w_out_vld_nxt = r_out_vld && !if_dec.out_ready;
    w_out_sym_nxt = r_out_sym;
    w_err_nxt     = 1'b0;

    if (if_dec.cfg_we || w_accept) begin
      w_state_nxt = ST_IDLE;
      w_code_nxt  = '0;
      w_first_nxt = '0;
      w_index_nxt = '0;
      w_len_nxt   = '0;
    end

    if (w_accept && !if_dec.cfg_we) begin
      if (w_hit && !w_ovf) begin
        w_out_vld_nxt = 1'b1;
        w_out_sym_nxt = w_sym;
      end else if (w_hit || w_last) begin
        w_err_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_ACC;
        w_code_nxt  = w_c[MAX_LEN-1:0];
        w_first_nxt = CW'((w_first_ext + WW'(w_count)) << 1);
        w_index_nxt = r_index + IW'(w_count);
        w_len_nxt   = r_len + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_code    <= '0;
      r_first   <= '0;
      r_index   <= '0;
      r_len     <= '0;
      r_out_vld <= 1'b0;
      r_out_sym <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_first   <= w_first_nxt;
      r_index   <= w_index_nxt;
      r_len     <= w_len_nxt;
      r_out_vld <= w_out_vld_nxt;
      r_out_sym <= w_out_sym_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign if_dec.in_ready    = w_in_ready;
  assign if_dec.out_valid   = r_out_vld;
  assign if_dec.out_sym     = r_out_sym;
  assign if_dec.err_invalid = r_err;
  assign if_dec.busy        = (r_state == ST_ACC);

endmodule

// File: tb/tb_huffman_canon_decoder.sv
// Directed bench for huffman_canon_decoder: table-driven code vectors over several loaded tables,
// hand sequences for back-pressure, async reset and table rewrite, plus a random-ready stream.
module tb_huffman_canon_decoder;
  import huffman_pkg::*;

  localparam int SYM_W   = 3;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 4;
  localparam int NVEC    = 13;

  typedef struct {
    int         tbl;
    int         len;
    logic [7:0] code;
    logic       exp_vld;
    logic [2:0] exp_sym;
    logic       exp_err;
  } vec_t;

  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  always #5 Clock = ~Clock;

  huffman_canon_decoder_if #(.SYM_W(SYM_W), .CNT_W(CNT_W)) bus ();

  huffman_canon_decoder #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .if_dec (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the bit.
  task automatic send_bit(input logic b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    do begin
      @(negedge Clock); #1;
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait actual=0 required=1");
    end
    @(posedge Clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic sel, input int addr, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_addr = SYM_W'(addr);
    bus.cfg_data = CNT_W'(data);
    @(posedge Clock); #1;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic load_table(input int t);
    case (t)
      1: begin
        cfg_write(CFG_SEL_COUNT, 0, 1); cfg_write(CFG_SEL_COUNT, 1, 1);
        cfg_write(CFG_SEL_COUNT, 2, 2); cfg_write(CFG_SEL_COUNT, 3, 0);
        cfg_write(CFG_SEL_SYM, 0, 5);   cfg_write(CFG_SEL_SYM, 1, 2);
        cfg_write(CFG_SEL_SYM, 2, 7);   cfg_write(CFG_SEL_SYM, 3, 0);
      end
      2: begin
        cfg_write(CFG_SEL_COUNT, 0, 0); cfg_write(CFG_SEL_COUNT, 1, 1);
        cfg_write(CFG_SEL_COUNT, 2, 0); cfg_write(CFG_SEL_COUNT, 3, 0);
        cfg_write(CFG_SEL_SYM, 0, 0);   cfg_write(CFG_SEL_SYM, 1, 1);
        cfg_write(CFG_SEL_SYM, 2, 2);   cfg_write(CFG_SEL_SYM, 3, 3);
      end
      default: begin
        cfg_write(CFG_SEL_COUNT, 0, 0); cfg_write(CFG_SEL_COUNT, 1, 0);
        cfg_write(CFG_SEL_COUNT, 2, 0); cfg_write(CFG_SEL_COUNT, 3, 15);
      end
    endcase
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [NVEC];
    int   cur_tbl;
    int   def_len  [7];
    int   def_code [7];
    int   exp_q [$];
    int   err_seen;
    bit   feed_done;

    def_len  = '{2, 2, 3, 3, 3, 4, 4};
    def_code = '{0, 1, 4, 5, 6, 14, 15};

    // default table, then table 1 {L1:1,L2:1,L3:2}, table 2 {L2:1}, table 3 {L4:15} (overflow)
    vecs[0]  = '{0, 2, 8'b00,   1'b1, 3'd0, 1'b0};
    vecs[1]  = '{0, 2, 8'b01,   1'b1, 3'd1, 1'b0};
    vecs[2]  = '{0, 3, 8'b100,  1'b1, 3'd2, 1'b0};
    vecs[3]  = '{0, 3, 8'b101,  1'b1, 3'd3, 1'b0};
    vecs[4]  = '{0, 3, 8'b110,  1'b1, 3'd4, 1'b0};
    vecs[5]  = '{0, 4, 8'b1110, 1'b1, 3'd5, 1'b0};
    vecs[6]  = '{0, 4, 8'b1111, 1'b1, 3'd6, 1'b0};
    vecs[7]  = '{1, 1, 8'b0,    1'b1, 3'd5, 1'b0};
    vecs[8]  = '{1, 2, 8'b10,   1'b1, 3'd2, 1'b0};
    vecs[9]  = '{1, 3, 8'b110,  1'b1, 3'd7, 1'b0};
    vecs[10] = '{1, 3, 8'b111,  1'b1, 3'd0, 1'b0};
    vecs[11] = '{2, 4, 8'b1111, 1'b0, 3'd0, 1'b1};
    vecs[12] = '{3, 4, 8'b1001, 1'b0, 3'd0, 1'b1};

    Reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sym", bus.out_sym, 0);
    chk("rst_err", bus.err_invalid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;

    cur_tbl = 0;
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].tbl != cur_tbl) begin
        load_table(vecs[i].tbl);
        cur_tbl = vecs[i].tbl;
      end
      for (int k = vecs[i].len - 1; k >= 0; k--) begin
        send_bit(vecs[i].code[k]);
        if (k != 0) chk($sformatf("v%0d_busy_mid", i), bus.busy, 1);
      end
      chk($sformatf("v%0d_out_valid", i), bus.out_valid, vecs[i].exp_vld);
      chk($sformatf("v%0d_err", i), bus.err_invalid, vecs[i].exp_err);
      chk($sformatf("v%0d_busy_end", i), bus.busy, 0);
      if (vecs[i].exp_vld) chk($sformatf("v%0d_out_sym", i), bus.out_sym, vecs[i].exp_sym);
      if (vecs[i].exp_err) begin
        @(posedge Clock); #1;
        chk($sformatf("v%0d_err_one_cycle", i), bus.err_invalid, 0);
      end
    end
    // after both invalid-code cases the decoder must resume cleanly (table 3 still loaded)
    send_bit(0); send_bit(0); send_bit(0); send_bit(0);
    chk("resume_out_valid", bus.out_valid, 1);
    chk("resume_out_sym", bus.out_sym, 0);

    // back-pressure on the default table
    do_reset();
    send_bit(0); send_bit(0);
    chk("bp_first_valid", bus.out_valid, 1);
    chk("bp_first_sym", bus.out_sym, 0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_bit    = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_valid_held", bus.out_valid, 1);
    chk("bp_sym_held", bus.out_sym, 0);
    chk("bp_bit_not_taken", bus.busy, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    send_bit(0); send_bit(1);
    chk("bp_second_valid", bus.out_valid, 1);
    chk("bp_second_sym", bus.out_sym, 1);

    // async reset mid-code, then mid-output
    send_bit(1); send_bit(1);
    chk("rmid_busy_before", bus.busy, 1);
    Reset = 1'b1;
    #1;
    chk("rmid_busy", bus.busy, 0);
    chk("rmid_out_valid", bus.out_valid, 0);
    Reset = 1'b0;
    send_bit(0); send_bit(0);
    chk("rmid_after_valid", bus.out_valid, 1);
    chk("rmid_after_sym", bus.out_sym, 0);
    send_bit(1); send_bit(0); send_bit(1);
    chk("rout_sym_before", bus.out_sym, 3);
    bus.out_ready = 1'b0;
    Reset = 1'b1;
    #1;
    chk("rout_out_valid", bus.out_valid, 0);
    chk("rout_out_sym", bus.out_sym, 0);
    Reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge Clock); #1;

    // table write drops a partial code without flagging it
    send_bit(1); send_bit(0);
    chk("cfg_busy_before", bus.busy, 1);
    cfg_write(CFG_SEL_SYM, 1, 6);
    chk("cfg_busy_after", bus.busy, 0);
    chk("cfg_no_err", bus.err_invalid, 0);
    send_bit(0); send_bit(1);
    chk("cfg_new_valid", bus.out_valid, 1);
    chk("cfg_new_sym", bus.out_sym, 6);
    chk("cfg_new_err", bus.err_invalid, 0);

    // random symbol stream, default table, random consumer stalls
    do_reset();
    feed_done = 1'b0;
    err_seen  = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int s;
          s = $urandom_range(0, 6);
          exp_q.push_back(s);
          for (int k = def_len[s] - 1; k >= 0; k--) begin
            logic [7:0] cw;
            cw = 8'(def_code[s]);
            send_bit(cw[k]);
          end
        end
        feed_done = 1'b1;
      end
      begin
        int cyc = 0;
        while ((!feed_done || exp_q.size() != 0) && cyc < 5000) begin
          @(negedge Clock);
          cyc++;
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.err_invalid) err_seen++;
          if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rnd_extra_symbol actual=%0d required=none", bus.out_sym);
            end else begin
              chk("rnd_sym", bus.out_sym, exp_q.pop_front());
            end
          end
        end
        if (cyc >= 5000) begin
          checks++;
          errors++;
          $display("FAIL rnd_timeout actual=%0d pending required=0", exp_q.size());
        end
      end
    join
    chk("rnd_err_count", err_seen, 0);
    bus.out_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
